// File: rtl/fib_pkg.sv
// Constants shared by the Fibonacci generator, its result FIFO and their benches.
package fib_pkg;

    localparam int FIB_W      = 6;
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

endpackage : fib_pkg

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, contents not reset.
module fifo_ram #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/fib_result_fifo.sv
// First-word-fall-through buffer for the Fibonacci result stream, with a sticky
// flag that records when the accepted sequence wraps modulo 2**WIDTH.
module fib_result_fifo
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       wrap_flag,
    input  logic                       clr_wrap
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a beat transfers on a rising edge where valid && ready.
    // in_ready and out_valid depend only on registered occupancy, never on
    // the partner's valid/ready, so a full FIFO refuses a push even while popping.

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] last_q;
    logic             last_vld;
    logic             wrap_q;

    logic push;
    logic pop;
    logic wrap_event;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign wrap_flag = wrap_q;

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign wrap_event = push && last_vld && (in_data < last_q);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A wrap detected on the same edge as clr_wrap keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q   <= '0;
            last_vld <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            if (push) begin
                last_q   <= in_data;
                last_vld <= 1'b1;
            end
            if (wrap_event) begin
                wrap_q <= 1'b1;
            end else if (clr_wrap) begin
                wrap_q <= 1'b0;
            end
        end
    end

endmodule : fib_result_fifo

// File: tb/tb_fib_result_fifo.sv
// Directed self-checking bench for fib_result_fifo.
module tb_fib_result_fifo;
    import fib_pkg::*;

    localparam int W = FIB_W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             wrap_flag;
    logic             clr_wrap;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    fib_result_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .wrap_flag (wrap_flag),
        .clr_wrap  (clr_wrap)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        exp_q.push_back(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        logic [W-1:0] e;
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        e = exp_q.pop_front();
        check_eq({tag, "_out_data"}, 32'(out_data), 32'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic push_pop(input string tag, input logic [W-1:0] v);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_eq({tag, "_out_data"}, 32'(out_data), 32'(e));
        exp_q.push_back(v);
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_one(tag);
        check_eq({tag, "_empty"}, 32'(empty), 32'd1);
        check_eq({tag, "_count"}, 32'(count), 32'd0);
    endtask

    logic [W-1:0] fib_vec [8];

    initial begin
        fib_vec = '{6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13};
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_wrap = 1'b0;
        #12 rst = 1'b1;

        // reset then idle
        repeat (5) tick();
        check_eq("idle_empty", 32'(empty), 32'd1);
        check_eq("idle_count", 32'(count), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
        check_eq("idle_wrap", 32'(wrap_flag), 32'd0);
        check_eq("idle_full", 32'(full), 32'd0);

        // fill to full with the first eight terms
        for (int i = 0; i < 8; i++) push(fib_vec[i]);
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_count", 32'(count), 32'd8);
        check_eq("fill_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 6'd21;
        tick();
        in_valid = 1'b0;
        check_eq("refused_count", 32'(count), 32'd8);
        drain("fill");
        check_eq("fill_wrap", 32'(wrap_flag), 32'd0);

        // wrap detection, clear, and set-wins-over-clear
        push(6'd34);
        push(6'd55);
        check_eq("pre_wrap", 32'(wrap_flag), 32'd0);
        push(6'd25);
        check_eq("wrap_set", 32'(wrap_flag), 32'd1);
        clr_wrap = 1'b1; tick(); clr_wrap = 1'b0;
        check_eq("wrap_clr", 32'(wrap_flag), 32'd0);
        push(6'd63);
        check_eq("no_wrap_63", 32'(wrap_flag), 32'd0);
        clr_wrap = 1'b1;
        push(6'd0);
        clr_wrap = 1'b0;
        check_eq("wrap_set_wins", 32'(wrap_flag), 32'd1);
        check_eq("wrap_count", 32'(count), 32'd5);
        drain("wrap");
        clr_wrap = 1'b1; tick(); clr_wrap = 1'b0;
        check_eq("wrap_clr2", 32'(wrap_flag), 32'd0);

        // simultaneous push/pop at count 3
        push(6'd1); push(6'd2); push(6'd3);
        for (int i = 0; i < 4; i++) begin
            push_pop("thru", 6'(4 + i));
            check_eq("thru_count", 32'(count), 32'd3);
        end
        drain("thru");

        // full: pop happens, push refused
        for (int i = 0; i < 8; i++) push(6'(8 + i));
        check_eq("full2_count", 32'(count), 32'd8);
        check_eq("full2_out_data", 32'(out_data), 32'd8);
        in_valid = 1'b1; in_data = 6'd16; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        void'(exp_q.pop_front());
        check_eq("full_pp_count", 32'(count), 32'd7);
        check_eq("full_pp_in_ready", 32'(in_ready), 32'd1);
        drain("full_pp");
        check_eq("full_pp_wrap", 32'(wrap_flag), 32'd0);

        // asynchronous reset mid-operation with count=5 and wrap_flag set
        push(6'd20); push(6'd21); push(6'd22); push(6'd23); push(6'd5);
        check_eq("pre_rst_count", 32'(count), 32'd5);
        check_eq("pre_rst_wrap", 32'(wrap_flag), 32'd1);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_wrap", 32'(wrap_flag), 32'd0);
        in_valid = 1'b1; in_data = 6'd40; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("rst_hold_count", 32'(count), 32'd0);
        #2 rst = 1'b1;
        push(6'd1);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd1);
        check_eq("post_rst_out_data", 32'(out_data), 32'd1);
        check_eq("post_rst_count", 32'(count), 32'd1);
        check_eq("post_rst_wrap", 32'(wrap_flag), 32'd0);
        drain("post_rst");

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fib_result_fifo
